rtc_bus_engine: RTL and testbench



---
 rtl/rtc_bus_engine.sv | 213 +++++++++++++++++++++
 tb/tb_rtc_bus_engine.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_engine.sv
`default_nettype none
// ============================================================================
// rtc_bus_engine : multiplexed address/data bus master for the external RTC
// Revision 1.0
// ============================================================================

module rtc_bus_engine #(
    parameter int                DATA_W = 8,
    parameter int                LEN_W  = 3,
    parameter int                T_SU   = 2,
    parameter int                T_PW   = 4,
    parameter int                T_H    = 2,
    parameter int                T_REC  = 2,
    parameter bit                CMD_EN = 1'b1,
    parameter logic [DATA_W-1:0] CMD    = DATA_W'(8'hF0)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [DATA_W-1:0] addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              wdata_take,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              done,
    output logic              cs_n,
    output logic              rd_n,
    output logic              wr_n,
    output logic              ad,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    input  logic [DATA_W-1:0] bus_in
);

    localparam int c_t_a   = (T_SU > T_PW) ? T_SU : T_PW;
    localparam int c_t_b   = (T_H > T_REC) ? T_H : T_REC;
    localparam int c_t_max = (c_t_a > c_t_b) ? c_t_a : c_t_b;
    localparam int c_cw    = $clog2(c_t_max + 1);

    localparam logic [c_cw-1:0] c_su_ld  = c_cw'(T_SU - 1);
    localparam logic [c_cw-1:0] c_pw_ld  = c_cw'(T_PW - 1);
    localparam logic [c_cw-1:0] c_h_ld   = c_cw'(T_H - 1);
    localparam logic [c_cw-1:0] c_rec_ld = c_cw'(T_REC - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        PH_SU  = 2'd0,
        PH_PW  = 2'd1,
        PH_H   = 2'd2,
        PH_REC = 2'd3
    } phase_t;

    state_t            r_state, w_state_nxt;
    phase_t            r_phase, w_phase_nxt;
    logic [c_cw-1:0]   r_cnt, w_cnt_nxt;
    logic [LEN_W-1:0]  r_beat, w_beat_nxt;
    logic              w_accept;

    logic              r_we;
    logic [DATA_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;

    logic              r_ready, r_take, r_rvalid, r_done, r_rd_cap;
    logic              r_cs_n, r_rd_n, r_wr_n, r_ad, r_oe;
    logic [DATA_W-1:0] r_bus_out, r_rdata;

    logic              w_active, w_is_read, w_first_su, w_drive;

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt;
        w_beat_nxt  = r_beat;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (CMD_EN && !we) ? ST_CMD : ST_ADDR;
                    w_phase_nxt = PH_SU;
                    w_cnt_nxt   = c_su_ld;
                    w_beat_nxt  = '0;
                end
            end
            ST_CMD, ST_ADDR, ST_DATA: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - c_cw'(1);
                end else begin
                    case (r_phase)
                        PH_SU: begin
                            w_phase_nxt = PH_PW;
                            w_cnt_nxt   = c_pw_ld;
                        end
                        PH_PW: begin
                            w_phase_nxt = PH_H;
                            w_cnt_nxt   = c_h_ld;
                        end
                        PH_H: begin
                            w_phase_nxt = PH_REC;
                            w_cnt_nxt   = c_rec_ld;
                        end
                        default: begin
                            // End of recovery: pick the next bus cycle.
                            w_phase_nxt = PH_SU;
                            w_cnt_nxt   = c_su_ld;
                            case (r_state)
                                ST_CMD:  w_state_nxt = r_we ? ST_FIN : ST_ADDR;
                                ST_ADDR: w_state_nxt = ST_DATA;
                                default: begin
                                    if (r_beat == r_len) begin
                                        w_state_nxt = (r_we && CMD_EN) ? ST_CMD : ST_FIN;
                                    end else begin
                                        w_beat_nxt  = r_beat + LEN_W'(1);
                                        w_state_nxt = ST_ADDR;
                                    end
                                end
                            endcase
                        end
                    endcase
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Pins are registered from the current state, so they lag it by one cycle.
    always_comb begin
        w_active   = (r_state == ST_CMD) || (r_state == ST_ADDR) || (r_state == ST_DATA);
        w_is_read  = (r_state == ST_DATA) && !r_we;
        w_first_su = w_active && (r_phase == PH_SU) && (r_cnt == c_su_ld);
        w_drive    = w_active && (r_phase != PH_REC);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_phase   <= PH_SU;
            r_cnt     <= '0;
            r_beat    <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_len     <= '0;
            r_ready   <= 1'b1;
            r_take    <= 1'b0;
            r_rvalid  <= 1'b0;
            r_done    <= 1'b0;
            r_rd_cap  <= 1'b0;
            r_cs_n    <= 1'b1;
            r_rd_n    <= 1'b1;
            r_wr_n    <= 1'b1;
            r_ad      <= 1'b1;
            r_oe      <= 1'b0;
            r_bus_out <= '0;
            r_rdata   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
            r_beat  <= w_beat_nxt;
            if (w_accept) begin
                r_we   <= we;
                r_addr <= addr;
                r_len  <= len;
            end
            r_ready  <= (w_state_nxt == ST_IDLE);
            r_done   <= (r_state == ST_FIN);
            r_cs_n   <= !w_drive;
            r_wr_n   <= !(w_active && (r_phase == PH_PW) && !w_is_read);
            r_rd_n   <= !(w_is_read && (r_phase == PH_PW));
            r_ad     <= !((r_state == ST_CMD) || (r_state == ST_ADDR));
            r_oe     <= w_drive && !w_is_read;
            r_take   <= w_first_su && (r_state == ST_DATA) && r_we;
            r_rd_cap <= w_is_read && (r_phase == PH_PW) && (r_cnt == '0);
            r_rvalid <= r_rd_cap;
            if (r_rd_cap) begin
                r_rdata <= bus_in;
            end
            // Bus value is loaded once per cycle and then held through hold.
            if (w_first_su) begin
                case (r_state)
                    ST_CMD:  r_bus_out <= CMD;
                    ST_ADDR: r_bus_out <= r_addr + DATA_W'(r_beat);
                    default: if (r_we) r_bus_out <= wdata;
                endcase
            end
        end
    end

    assign ready       = r_ready;
    assign wdata_take  = r_take;
    assign rdata       = r_rdata;
    assign rdata_valid = r_rvalid;
    assign done        = r_done;
    assign cs_n        = r_cs_n;
    assign rd_n        = r_rd_n;
    assign wr_n        = r_wr_n;
    assign ad          = r_ad;
    assign bus_out     = r_bus_out;
    assign bus_oe      = r_oe;

endmodule

`default_nettype wire

// File: tb/tb_rtc_bus_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_rtc_bus_engine : directed bench for rtc_bus_engine (three parameter sets)
// Revision 1.0
// ============================================================================

module tb_rtc_bus_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_a, req_b, req_c, we;
    logic [7:0] addr, wdata, bus_in;
    logic [2:0] len;

    logic       ready_a, take_a, rv_a, done_a, cs_n_a, rd_n_a, wr_n_a, ad_a, oe_a;
    logic       ready_b, take_b, rv_b, done_b, cs_n_b, rd_n_b, wr_n_b, ad_b, oe_b;
    logic       ready_c, take_c, rv_c, done_c, cs_n_c, rd_n_c, wr_n_c, ad_c, oe_c;
    logic [7:0] rdata_a, bus_out_a, rdata_b, bus_out_b, rdata_c, bus_out_c;

    logic       m_ready, m_take, m_rv, m_done, m_cs_n, m_rd_n, m_wr_n, m_ad, m_oe;
    logic [7:0] m_rdata, m_bus_out;

    always #5 clk = ~clk;

    rtc_bus_engine u_dut_a (
        .clk(clk), .reset(reset), .req(req_a), .we(we), .addr(addr), .len(len),
        .wdata(wdata), .ready(ready_a), .wdata_take(take_a), .rdata(rdata_a),
        .rdata_valid(rv_a), .done(done_a), .cs_n(cs_n_a), .rd_n(rd_n_a),
        .wr_n(wr_n_a), .ad(ad_a), .bus_out(bus_out_a), .bus_oe(oe_a), .bus_in(bus_in)
    );

    rtc_bus_engine #(.CMD_EN(1'b0)) u_dut_b (
        .clk(clk), .reset(reset), .req(req_b), .we(we), .addr(addr), .len(len),
        .wdata(wdata), .ready(ready_b), .wdata_take(take_b), .rdata(rdata_b),
        .rdata_valid(rv_b), .done(done_b), .cs_n(cs_n_b), .rd_n(rd_n_b),
        .wr_n(wr_n_b), .ad(ad_b), .bus_out(bus_out_b), .bus_oe(oe_b), .bus_in(bus_in)
    );

    rtc_bus_engine #(.T_SU(1), .T_PW(1), .T_H(1), .T_REC(1)) u_dut_c (
        .clk(clk), .reset(reset), .req(req_c), .we(we), .addr(addr), .len(len),
        .wdata(wdata), .ready(ready_c), .wdata_take(take_c), .rdata(rdata_c),
        .rdata_valid(rv_c), .done(done_c), .cs_n(cs_n_c), .rd_n(rd_n_c),
        .wr_n(wr_n_c), .ad(ad_c), .bus_out(bus_out_c), .bus_oe(oe_c), .bus_in(bus_in)
    );

    int sel = 0;

    always_comb begin
        {m_ready, m_take, m_rv, m_done, m_cs_n, m_rd_n, m_wr_n, m_ad, m_oe} =
            {ready_a, take_a, rv_a, done_a, cs_n_a, rd_n_a, wr_n_a, ad_a, oe_a};
        m_rdata   = rdata_a;
        m_bus_out = bus_out_a;
        case (sel)
            1: begin
                {m_ready, m_take, m_rv, m_done, m_cs_n, m_rd_n, m_wr_n, m_ad, m_oe} =
                    {ready_b, take_b, rv_b, done_b, cs_n_b, rd_n_b, wr_n_b, ad_b, oe_b};
                m_rdata   = rdata_b;
                m_bus_out = bus_out_b;
            end
            2: begin
                {m_ready, m_take, m_rv, m_done, m_cs_n, m_rd_n, m_wr_n, m_ad, m_oe} =
                    {ready_c, take_c, rv_c, done_c, cs_n_c, rd_n_c, wr_n_c, ad_c, oe_c};
                m_rdata   = rdata_c;
                m_bus_out = bus_out_c;
            end
            default: ;
        endcase
    end

    // Write data follows the take count; read data follows the valid count.
    logic [7:0] wtab [4];
    int         take_base = 0, rv_base = 0, rbase = 0;
    int         n_take = 0, n_rv = 0;
    logic [1:0] widx;
    assign widx   = 2'(n_take - take_base);
    assign wdata  = wtab[widx];
    assign bus_in = m_rd_n ? 8'h00 : 8'(rbase + n_rv - rv_base);

    typedef struct {
        bit         is_wr;
        logic       ad;
        logic       oe;
        logic [7:0] bus;
        int         width;
        int         fcyc;
        bit         unstable;
    } pulse_t;

    pulse_t     plog[$];
    int         cslog[$];
    logic [7:0] rlog[$];
    int         cyc = 0, n_done = 0, n_csfall = 0, done_cyc = 0, proto_err = 0, n_oe_data = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin : monitor
        pulse_t cur;
        logic   p_cs, p_low, w_low;
        p_cs  = 1'b1;
        p_low = 1'b0;
        cur   = '{default: '0};
        forever begin
            @(negedge clk);
            w_low = !m_wr_n || !m_rd_n;
            if (!m_wr_n && !m_rd_n) proto_err++;
            if (w_low && m_cs_n) proto_err++;
            if (!m_cs_n && m_ad && m_oe) n_oe_data++;
            if (p_cs && !m_cs_n) begin
                n_csfall++;
                cslog.push_back(cyc);
            end
            if (w_low && !p_low) begin
                cur.is_wr    = !m_wr_n;
                cur.ad       = m_ad;
                cur.oe       = m_oe;
                cur.bus      = m_bus_out;
                cur.width    = 1;
                cur.fcyc     = cyc;
                cur.unstable = 1'b0;
            end else if (w_low) begin
                cur.width++;
                if (m_ad !== cur.ad || m_oe !== cur.oe || m_bus_out !== cur.bus) cur.unstable = 1'b1;
            end else if (p_low) begin
                plog.push_back(cur);
            end
            if (m_take) n_take++;
            if (m_rv) begin
                n_rv++;
                rlog.push_back(m_rdata);
            end
            if (m_done) begin
                n_done++;
                done_cyc = cyc;
            end
            p_cs  = m_cs_n;
            p_low = w_low;
        end
    end

    int n_chk = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_pulse(input string tag, input int idx, input bit w, input logic a,
                             input logic o, input bit cb, input logic [7:0] b, input int wd);
        pulse_t e;
        if (idx >= plog.size()) begin
            check({tag, "_exists"}, 32'(plog.size()), 32'(idx + 1));
            return;
        end
        e = plog[idx];
        check({tag, "_kind"}, {28'd0, e.is_wr, e.ad, e.oe, e.unstable}, {28'd0, w, a, o, 1'b0});
        if (cb) check({tag, "_bus"}, 32'(e.bus), 32'(b));
        check({tag, "_width"}, 32'(e.width), 32'(wd));
    endtask

    task automatic set_req(input int s, input logic v);
        case (s)
            0:       req_a = v;
            1:       req_b = v;
            default: req_c = v;
        endcase
    endtask

    task automatic start_txn(input int s, input logic w, input logic [7:0] a,
                             input logic [2:0] l, output int k);
        @(negedge clk);
        #2;
        we   = w;
        addr = a;
        len  = l;
        check("ready_idle", 32'(m_ready), 32'd1);
        set_req(s, 1'b1);
        @(posedge clk);
        #1;
        k = cyc;
        set_req(s, 1'b0);
    endtask

    task automatic wait_done(input int n0, input int limit, input string tag);
        int i;
        i = 0;
        while (n_done == n0 && i < limit) begin
            @(negedge clk);
            #2;
            i++;
        end
        check({tag, "_done_seen"}, 32'(n_done - n0), 32'd1);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

    initial begin : main
        int k, d, p0, c0, d0, r0, o0, t0, i;
        reset = 1'b1;
        req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
        we = 1'b0; addr = '0; len = '0;
        wtab = '{8'h00, 8'h00, 8'h00, 8'h00};
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #2;
        check("rst_ctrl", {23'd0, m_cs_n, m_rd_n, m_wr_n, m_ad, m_oe, m_ready, m_rv, m_done, m_take},
              {23'd0, 9'b111101000});
        check("rst_bus_out", 32'(m_bus_out), 32'h0);
        check("rst_rdata", 32'(m_rdata), 32'h0);

        // Single write, defaults: ADDR 21, DATA 5A, CMD F0.
        sel = 0;
        p0 = plog.size(); c0 = n_csfall; d0 = n_done; t0 = n_take;
        take_base = n_take;
        wtab = '{8'h5A, 8'h00, 8'h00, 8'h00};
        start_txn(0, 1'b1, 8'h21, 3'd0, k);
        wait_done(d0, 60, "wr1");
        check("wr1_done_lat", 32'(done_cyc - k), 32'd31);
        check("wr1_take_cnt", 32'(n_take - t0), 32'd1);
        check("wr1_pulses", 32'(plog.size() - p0), 32'd3);
        check("wr1_cs_fall", 32'((cslog.size() > c0) ? cslog[c0] - k : -1), 32'd1);
        check("wr1_setup", 32'((plog.size() > p0) ? plog[p0].fcyc - k : -1), 32'd3);
        check("wr1_period", 32'((plog.size() > p0 + 1) ? plog[p0+1].fcyc - plog[p0].fcyc : -1), 32'd10);
        chk_pulse("wr1_addr", p0,     1'b1, 1'b0, 1'b1, 1'b1, 8'h21, 4);
        chk_pulse("wr1_data", p0 + 1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h5A, 4);
        chk_pulse("wr1_cmd",  p0 + 2, 1'b1, 1'b0, 1'b1, 1'b1, 8'hF0, 4);

        // Single read: CMD F0, ADDR 21, then a read data cycle returning 37.
        p0 = plog.size(); d0 = n_done; r0 = rlog.size(); o0 = n_oe_data;
        rbase = 8'h37; rv_base = n_rv;
        start_txn(0, 1'b0, 8'h21, 3'd0, k);
        wait_done(d0, 60, "rd1");
        check("rd1_done_lat", 32'(done_cyc - k), 32'd31);
        chk_pulse("rd1_cmd",  p0,     1'b1, 1'b0, 1'b1, 1'b1, 8'hF0, 4);
        chk_pulse("rd1_addr", p0 + 1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h21, 4);
        chk_pulse("rd1_data", p0 + 2, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4);
        check("rd1_oe_in_data", 32'(n_oe_data - o0), 32'd0);
        check("rd1_rv_cnt", 32'(rlog.size() - r0), 32'd1);
        check("rd1_rdata", 32'((rlog.size() > r0) ? rlog[r0] : 8'hXX), 32'h37);
        check("rd1_rdata_hold", 32'(m_rdata), 32'h37);

        // Burst write without command cycle, address wraps FF -> 00.
        sel = 1;
        p0 = plog.size(); d0 = n_done; t0 = n_take;
        take_base = n_take;
        wtab = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        start_txn(1, 1'b1, 8'hFE, 3'd3, k);
        wait_done(d0, 120, "burst");
        check("burst_done_lat", 32'(done_cyc - k), 32'd81);
        check("burst_take_cnt", 32'(n_take - t0), 32'd4);
        check("burst_pulses", 32'(plog.size() - p0), 32'd8);
        for (int b = 0; b < 4; b++) begin
            chk_pulse($sformatf("burst_a%0d", b), p0 + 2*b,     1'b1, 1'b0, 1'b1, 1'b1,
                      8'(8'hFE + b), 4);
            chk_pulse($sformatf("burst_d%0d", b), p0 + 2*b + 1, 1'b1, 1'b1, 1'b1, 1'b1,
                      wtab[b], 4);
        end

        // req held high while busy: one transaction, then a back-to-back one.
        sel = 0;
        c0 = n_csfall; d0 = n_done;
        @(negedge clk);
        #2;
        we = 1'b1; addr = 8'h10; len = 3'd0;
        wtab = '{8'h77, 8'h77, 8'h77, 8'h77};
        take_base = n_take;
        req_a = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        wait_done(d0, 60, "spam1");
        d = done_cyc;
        check("spam_one_txn", 32'(n_csfall - c0), 32'd3);
        check("spam_done_lat", 32'(d - k), 32'd31);
        check("spam_ready_in_done", 32'(m_ready), 32'd1);
        @(posedge clk);
        #1;
        req_a = 1'b0;
        wait_done(d0 + 1, 60, "spam2");
        check("spam_done_cnt", 32'(n_done - d0), 32'd2);
        // Accepted at the edge closing the done cycle, so cs_n falls one edge later.
        check("b2b_cs_fall", 32'((cslog.size() > c0 + 3) ? cslog[c0+3] - d : -1), 32'd2);

        // Asynchronous reset during the strobe of a write data cycle.
        wtab = '{8'h99, 8'h99, 8'h99, 8'h99};
        take_base = n_take;
        start_txn(0, 1'b1, 8'h30, 3'd0, k);
        i = 0;
        while (!(m_wr_n === 1'b0 && m_ad === 1'b1) && i < 60) begin
            @(negedge clk);
            #2;
            i++;
        end
        check("rst_reached_pw", {30'd0, m_wr_n, m_ad}, 32'b01);
        d0 = n_done;
        #1 reset = 1'b0;
        #1;
        check("rst_async_pins", {28'd0, m_cs_n, m_wr_n, m_rd_n, m_oe}, {28'd0, 4'b1110});
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        #2;
        check("rst_no_done", 32'(n_done - d0), 32'd0);
        check("rst_ready", 32'(m_ready), 32'd1);

        // Minimum timing read of two beats.
        sel = 2;
        p0 = plog.size(); d0 = n_done; r0 = rlog.size();
        rbase = 8'h40; rv_base = n_rv;
        start_txn(2, 1'b0, 8'h80, 3'd1, k);
        wait_done(d0, 60, "fast");
        check("fast_done_lat", 32'(done_cyc - k), 32'd21);
        check("fast_setup", 32'((plog.size() > p0) ? plog[p0].fcyc - k : -1), 32'd2);
        chk_pulse("fast_cmd", p0,     1'b1, 1'b0, 1'b1, 1'b1, 8'hF0, 1);
        chk_pulse("fast_a0",  p0 + 1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h80, 1);
        chk_pulse("fast_d0",  p0 + 2, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1);
        chk_pulse("fast_a1",  p0 + 3, 1'b1, 1'b0, 1'b1, 1'b1, 8'h81, 1);
        chk_pulse("fast_d1",  p0 + 4, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1);
        check("fast_rv_cnt", 32'(rlog.size() - r0), 32'd2);
        check("fast_rdata0", 32'((rlog.size() > r0) ? rlog[r0] : 8'hXX), 32'h40);
        check("fast_rdata1", 32'((rlog.size() > r0 + 1) ? rlog[r0+1] : 8'hXX), 32'h41);

        check("protocol", 32'(proto_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
